// File: rtl/rate_pkg.sv
// Shared definitions for the multi-channel rate tick generator: default
// widths, the channel state encoding, the rate-code lookup and the
// prescaler divisor helper.
package rate_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int CNT_W_DEF = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Rate code to period in milliseconds, zero-extended to the counter width
  function automatic logic [CNT_W_DEF-1:0] rate_lut(input logic [SEL_W_DEF-1:0] code);
    logic [CNT_W_DEF-1:0] ms;
    case (code)
      3'd0: ms = CNT_W_DEF'(1);
      3'd1: ms = CNT_W_DEF'(2);
      3'd2: ms = CNT_W_DEF'(5);
      3'd3: ms = CNT_W_DEF'(10);
      3'd4: ms = CNT_W_DEF'(20);
      3'd5: ms = CNT_W_DEF'(50);
      3'd6: ms = CNT_W_DEF'(100);
      3'd7: ms = CNT_W_DEF'(200);
    endcase
    return ms;
  endfunction

  // Base clock cycles per millisecond; the clock must be an integer
  // multiple of 1 kHz and give at least two cycles per millisecond
  function automatic int calc_ms_div(input int clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction

endpackage

// File: rtl/rate_tick_chan.sv
// One tick channel: an IDLE/RUN FSM that counts 1 ms strobes and emits a
// one-cycle tick at the end of each period. The rate code is only taken
// on entry to RUN and at period boundaries, so mid-period changes of R
// never shorten or stretch a period in progress.
module rate_tick_chan
  import rate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_strobe,
  input  logic             en,
  input  logic [SEL_W-1:0] R,
  output logic             tick,
  output logic [CNT_W-1:0] active_rate,
  output logic             pending
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] msCnt_q, msCnt_d;
  logic [CNT_W-1:0] activeRate_q, activeRate_d;
  logic [SEL_W-1:0] curCode_q, curCode_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] lutRate;

  assign lutRate = CNT_W'(rate_lut(R));

  // State register; reset puts the channel back to the 1 ms rate in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      msCnt_q      <= '0;
      activeRate_q <= CNT_W'(1);
      curCode_q    <= '0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      msCnt_q      <= msCnt_d;
      activeRate_q <= activeRate_d;
      curCode_q    <= curCode_d;
      tick_q       <= tick_d;
    end
  end

  // Next state: load on enable, count strobes, reload the rate at the boundary
  always_comb begin
    state_d      = state_q;
    msCnt_d      = msCnt_q;
    activeRate_d = activeRate_q;
    curCode_d    = curCode_q;
    tick_d       = 1'b0;
    case (state_q)
      IDLE: begin
        msCnt_d = '0;
        if (en) begin
          state_d      = RUN;
          curCode_d    = R;
          activeRate_d = lutRate;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          msCnt_d = '0;
        end else if (ms_strobe) begin
          if (msCnt_q == activeRate_q - CNT_W'(1)) begin
            tick_d       = 1'b1;
            msCnt_d      = '0;
            curCode_d    = R;
            activeRate_d = lutRate;
          end else begin
            msCnt_d = msCnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick        = tick_q;
  assign active_rate = activeRate_q;
  assign pending     = (state_q == RUN) && (R != curCode_q);

endmodule

// File: rtl/rate_tick_gen.sv
// Multi-channel periodic tick generator. A shared prescaler produces a
// 1 ms strobe from the base clock; each channel divides that strobe by
// its own selectable rate. ms_tick and the channel ticks are both
// registered from the same strobe edge, so they line up cycle for cycle.
module rate_tick_gen
  import rate_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 4000000,
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SEL_W       = SEL_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*SEL_W-1:0] R,
  output logic                    ms_tick,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*CNT_W-1:0] active_rate,
  output logic [NUM_CH-1:0]       pending
);

  localparam int MS_DIV = calc_ms_div(CLK_FREQ_HZ);
  localparam int PRE_W  = $clog2(MS_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);

  logic [PRE_W-1:0] preCnt_q, preCnt_d;
  logic             msTick_q;
  logic             msStrobe;

  assign msStrobe = (preCnt_q == PRE_LAST);

  // Free-running prescaler wrapping every MS_DIV cycles
  always_comb begin
    preCnt_d = msStrobe ? '0 : preCnt_q + PRE_W'(1);
  end

  // Prescaler register and the registered copy of the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preCnt_q <= '0;
      msTick_q <= 1'b0;
    end else begin
      preCnt_q <= preCnt_d;
      msTick_q <= msStrobe;
    end
  end

  assign ms_tick = msTick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    rate_tick_chan #(
      .CNT_W(CNT_W),
      .SEL_W(SEL_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .ms_strobe  (msStrobe),
      .en         (en[i]),
      .R          (R[i*SEL_W +: SEL_W]),
      .tick       (tick[i]),
      .active_rate(active_rate[i*CNT_W +: CNT_W]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Bench for rate_tick_gen with a 4 kHz clock (4 cycles per ms) and four
// channels. A behavioural model advances on every clock edge and queues
// the outputs it expects; a negedge checker pops and compares them.
// Directed scenarios add explicit checks on latency, periods and resets.
module tb_rate_tick_gen;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 24;
  localparam int MS_DIV = 4;

  logic                    clk   = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH-1:0]       en    = '0;
  logic [NUM_CH*SEL_W-1:0] R     = '0;
  logic                    ms_tick;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH*CNT_W-1:0] active_rate;
  logic [NUM_CH-1:0]       pending;

  int checkCount = 0;
  int errCount   = 0;

  always #5 clk = ~clk;

  rate_tick_gen #(
    .CLK_FREQ_HZ(4000),
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .SEL_W      (SEL_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .R          (R),
    .ms_tick    (ms_tick),
    .tick       (tick),
    .active_rate(active_rate),
    .pending    (pending)
  );

  // Model state: "left" counts the strobes still to go before the next tick
  typedef struct packed {
    int                     pre;
    logic                   msTick;
    logic [NUM_CH-1:0]      tick;
    logic [NUM_CH-1:0]      run;
    logic [NUM_CH-1:0][2:0] code;
    logic [NUM_CH-1:0][7:0] rate;
    logic [NUM_CH-1:0][7:0] left;
  } model_t;

  model_t mSt;
  model_t sbQ[$];

  function automatic logic [7:0] lutRef(input logic [2:0] c);
    case (c)
      3'd0: return 8'd1;
      3'd1: return 8'd2;
      3'd2: return 8'd5;
      3'd3: return 8'd10;
      3'd4: return 8'd20;
      3'd5: return 8'd50;
      3'd6: return 8'd100;
      default: return 8'd200;
    endcase
  endfunction

  function automatic model_t resetModel();
    model_t n;
    n = '0;
    for (int ch = 0; ch < NUM_CH; ch++) n.rate[ch] = 8'd1;
    return n;
  endfunction

  function automatic model_t stepModel(input model_t s, input logic [NUM_CH-1:0] enV,
                                       input logic [NUM_CH*SEL_W-1:0] rV);
    model_t n;
    logic strobe;
    logic [2:0] rc;
    n = s;
    strobe = (s.pre == MS_DIV - 1);
    n.pre = strobe ? 0 : s.pre + 1;
    n.msTick = strobe;
    n.tick = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rc = rV[ch*SEL_W +: SEL_W];
      if (!s.run[ch]) begin
        if (enV[ch]) begin
          n.run[ch]  = 1'b1;
          n.code[ch] = rc;
          n.rate[ch] = lutRef(rc);
          n.left[ch] = lutRef(rc);
        end
      end else if (!enV[ch]) begin
        n.run[ch] = 1'b0;
      end else if (strobe) begin
        if (s.left[ch] == 8'd1) begin
          n.tick[ch] = 1'b1;
          n.code[ch] = rc;
          n.rate[ch] = lutRef(rc);
          n.left[ch] = lutRef(rc);
        end else begin
          n.left[ch] = s.left[ch] - 8'd1;
        end
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic checkSnapshot(input model_t s);
    logic expPend;
    checkOutput("ms_tick", {31'd0, ms_tick}, {31'd0, s.msTick});
    checkOutput("tick", {28'd0, tick}, {28'd0, s.tick});
    for (int ch = 0; ch < NUM_CH; ch++) begin
      expPend = s.run[ch] && (R[ch*SEL_W +: SEL_W] != s.code[ch]);
      checkOutput($sformatf("active_rate%0d", ch), {8'd0, active_rate[ch*CNT_W +: CNT_W]},
                  {24'd0, s.rate[ch]});
      checkOutput($sformatf("pending%0d", ch), {31'd0, pending[ch]}, {31'd0, expPend});
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] enV, input logic [NUM_CH*SEL_W-1:0] rV,
                               input int n);
    @(posedge clk);
    #2;
    en = enV;
    R  = rV;
    repeat (n) @(posedge clk);
  endtask

  // Reference model: advance one cycle per edge and queue the expected outputs
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mSt <= resetModel();
      sbQ.delete();
    end else begin
      mSt <= stepModel(mSt, en, R);
      sbQ.push_back(stepModel(mSt, en, R));
    end
  end

  // Compare the DUT against the queued expectation in the middle of each cycle
  always @(negedge clk) begin
    if (!reset && sbQ.size() > 0) checkSnapshot(sbQ.pop_front());
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cnt;
    int  cntB;
    int  edges;
    bit  found;

    // Reset and idle
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_tick", {28'd0, tick}, 32'd0);
    checkOutput("rst_ms_tick", {31'd0, ms_tick}, 32'd0);
    checkOutput("rst_pending", {28'd0, pending}, 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++)
      checkOutput($sformatf("rst_rate%0d", ch), {8'd0, active_rate[ch*CNT_W +: CNT_W]}, 32'd1);
    cnt = 0;
    cntB = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ms_tick) cnt++;
      if (tick != '0) cntB++;
    end
    checkOutput("idle_ms_ticks", cnt, 10);
    checkOutput("idle_ticks", cntB, 0);

    // Basic rates: ch0 at 1 ms, ch1 at 5 ms
    applyStimulus(4'b0011, 12'b000_000_010_000, 20);
    #1;
    checkOutput("basic_rate0", {8'd0, active_rate[0 +: CNT_W]}, 32'd1);
    checkOutput("basic_rate1", {8'd0, active_rate[CNT_W +: CNT_W]}, 32'd5);
    cnt = 0;
    cntB = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (tick[0]) cnt++;
      if (tick[1]) cntB++;
    end
    checkOutput("basic_ticks0", cnt, 10);
    checkOutput("basic_ticks1", cntB, 2);

    // Boundary switch: ch1 from 10 ms to 2 ms after three strobes
    applyStimulus('0, '0, 3);
    applyStimulus(4'b0010, 12'b000_000_011_000, 0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (mSt.run[1] && mSt.left[1] == 8'd7) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("sw_wait", {31'd0, found}, 32'd1);
    #1 R[SEL_W +: SEL_W] = 3'b001;
    #1;
    checkOutput("sw_pending", {31'd0, pending[1]}, 32'd1);
    checkOutput("sw_rate_old", {8'd0, active_rate[CNT_W +: CNT_W]}, 32'd10);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (tick[1]) begin
        found = 1'b1;
        break;
      end
      if (pending[1] !== 1'b1) cnt = -1;
    end
    checkOutput("sw_tick_seen", {31'd0, found}, 32'd1);
    checkOutput("sw_rate_new", {8'd0, active_rate[CNT_W +: CNT_W]}, 32'd2);
    checkOutput("sw_pending_clr", {31'd0, pending[1]}, 32'd0);
    edges = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      edges++;
      #1;
      if (tick[1]) break;
    end
    checkOutput("sw_period", edges, 8);

    // Disable on the terminal edge of a 2 ms period
    applyStimulus('0, '0, 3);
    applyStimulus(4'b0001, 12'b000_000_000_001, 0);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (mSt.run[0] && mSt.left[0] == 8'd1 && mSt.pre == MS_DIV - 1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("dis_wait", {31'd0, found}, 32'd1);
    #1 en = '0;
    cnt = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (tick[0]) cnt++;
    end
    checkOutput("dis_no_tick", cnt, 0);
    checkOutput("dis_pending", {31'd0, pending[0]}, 32'd0);
    #1 en = 4'b0001;
    cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ms_tick) cnt++;
      if (tick[0]) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reen_tick_seen", {31'd0, found}, 32'd1);
    checkOutput("reen_strobes", cnt, 2);

    // Asynchronous reset in the middle of a 200 ms period
    applyStimulus('0, '0, 3);
    applyStimulus(4'b0010, 12'b000_000_111_000, 0);
    found = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (mSt.run[1] && mSt.left[1] == 8'd50) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("ar_wait", {31'd0, found}, 32'd1);
    checkOutput("ar_rate_pre", {8'd0, active_rate[CNT_W +: CNT_W]}, 32'd200);
    #1 reset = 1'b1;
    #1;
    checkOutput("ar_tick", {28'd0, tick}, 32'd0);
    checkOutput("ar_ms_tick", {31'd0, ms_tick}, 32'd0);
    checkOutput("ar_rate1", {8'd0, active_rate[CNT_W +: CNT_W]}, 32'd1);
    checkOutput("ar_pending", {28'd0, pending}, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    edges = 0;
    for (int k = 0; k < 900; k++) begin
      @(posedge clk);
      edges++;
      #1;
      if (tick[1]) break;
    end
    checkOutput("ar_first_tick", edges, 800);

    // Maximum code on all four channels
    applyStimulus('0, '0, 3);
    applyStimulus(4'b1111, 12'hFFF, 0);
    cnt = 0;
    cntB = 0;
    repeat (1700) begin
      @(posedge clk);
      #1;
      if (tick == 4'b1111) cnt++;
      else if (tick != '0) cntB++;
    end
    checkOutput("max_all_ticks", cnt, 2);
    checkOutput("max_partial", cntB, 0);
    for (int ch = 0; ch < NUM_CH; ch++)
      checkOutput($sformatf("max_rate%0d", ch), {8'd0, active_rate[ch*CNT_W +: CNT_W]}, 32'd200);

    @(negedge clk);
    #1;
    checkOutput("sb_drain", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/rate_tick_gen.md
Name: rate_tick_gen

Overview:
Multi-channel periodic tick generator and the parametrised successor of the 3-bit rate selector. A shared prescaler divides the base clock to a 1 ms strobe. Each channel decodes its own 3-bit rate code (1/2/5/10/20/50/100/200 ms) and emits a one-cycle tick every period. Rate changes are applied glitch-free at period boundaries, and each channel has its own enable, so acquisition and sampling logic can run independent rates from one block.

Parameters:
CLK_FREQ_HZ, 4000000, base clock frequency; MS_DIV = CLK_FREQ_HZ/1000 (must be ≥2, integer)
NUM_CH, 2, number of independent tick channels (1..8)
CNT_W, 24, width of rate value and per-channel ms counter
SEL_W, 3, rate code width (fixed LUT covers 8 codes)

Ports:
clk  in  1  base clock
reset  in  1  asynchronous, active-high reset
en  in  NUM_CH  per-channel enable, level
R  in  NUM_CH*SEL_W  per-channel rate code, channel i at [i*SEL_W +: SEL_W]
ms_tick  out  1  registered 1 ms strobe, one cycle wide
tick  out  NUM_CH  per-channel period tick, one cycle wide
active_rate  out  NUM_CH*CNT_W  rate (ms) currently in force per channel
pending  out  NUM_CH  1 = R differs from the code in force; change is queued

Behaviour:
- Reset (async, active-high): prescaler=0, ms_tick=0, all channels in IDLE, tick=0, ms_cnt=0, active_rate=1 (code 000), cur_code=000, pending=0.
- Prescaler: free-running 0..MS_DIV-1, wraps to 0. Internal ms_strobe = (pre_cnt==MS_DIV-1). ms_tick is ms_strobe registered, so it is high in the cycle after the terminal count.
- LUT: 000→1, 001→2, 010→5, 011→10, 100→20, 101→50, 110→100, 111→200. The result is zero-extended to CNT_W.
- Per-channel FSM, states IDLE and RUN:
  - IDLE: tick=0, ms_cnt=0. When en=1 at a clock edge, load cur_code=R and active_rate=LUT(R), then go to RUN.
  - RUN, with en=0 at an edge: go to IDLE and clear ms_cnt. No tick is issued, even if that edge is terminal.
  - RUN, with ms_strobe=1 and ms_cnt==active_rate-1: tick=1 next cycle, ms_cnt=0, reload cur_code/active_rate from R as sampled at that edge.
  - RUN, with ms_strobe=1 and ms_cnt < active_rate-1: ms_cnt+1.
  - RUN, otherwise: hold.
- tick latency: aligned with ms_tick, i.e. the cycle after the terminal ms_strobe edge.
- First period after enable is counted from the next ms_strobe. The first tick arrives on the active_rate-th ms_strobe after entering RUN, giving jitter < 1 ms against en.
- pending = RUN && (R != cur_code), combinational from registered state. It is 0 in IDLE.
- R changes mid-period are ignored until the boundary. Multiple changes within a period: only the value at the boundary edge counts.
- en toggling 1→0→1: restarts the period, and the new R is loaded on entry.
- Reset asserted mid-period: everything returns to reset values immediately; no tick during or after reset until a full period elapses in RUN.
- Channels are fully independent. Simultaneous ticks on several channels are legal.

Decomposition:
- Package rate_pkg holds:
  - SEL_W and CNT_W defaults
  - enum ch_state_t {IDLE, RUN}
  - function rate_lut(code) returning CNT_W-bit ms value
  - function calc_ms_div(CLK_FREQ_HZ)
- Sub-module rate_tick_chan: one channel's FSM, counter, LUT reload and pending logic, with inputs ms_strobe, en, R. It is instantiated NUM_CH times via generate.
- Top holds the prescaler and ms_tick register.

Test Plan:
- All sims use CLK_FREQ_HZ=4000, so MS_DIV=4.
- Reset/idle: hold reset for 5 cycles, release, en=00 for 40 cycles → tick=00 throughout, ms_tick every 4 cycles, active_rate=1/1, pending=00.
- Basic rates: ch0 R=000, ch1 R=010, en=11 → ch0 ticks every 4 cycles; ch1 ticks every 20 cycles, coincident with ms_tick; active_rate = 1 and 5.
- Boundary switch: ch1 R=011 running, change R to 001 at ms_cnt=3 → pending=1 until the 10th strobe, tick there, then ticks every 8 cycles; active_rate goes 10→2 in the tick cycle.
- Disable on terminal edge: ch0 R=001, drop en on the cycle of the 2nd strobe → no tick, state IDLE. Re-enable → first tick on the 2nd following strobe.
- Async reset mid-run: ch1 R=111 at ms_cnt=150, assert reset between clock edges → outputs are 0 immediately without a clock edge. After release with en=1, first tick after 200 strobes (~800 cycles).
- Max code/width: all channels R=111 with NUM_CH=4 → four simultaneous ticks every 800 cycles and no ms_cnt overflow past 199.
